// File: rtl/envelope_mixer_pkg.sv
// Shared types and constants for the envelope mixer.
// The ADSR state enum, the default level width and the sample saturation limits.
package synthPKG;

    typedef logic signed [15:0] synth_sig;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int ENV_W_DEF = 8;

    localparam synth_sig SYNTH_MAX = 16'sh7FFF;
    localparam synth_sig SYNTH_MIN = 16'sh8000;

endpackage

// File: rtl/envelope_gen.sv
// ADSR envelope generator: state machine plus level datapath, advancing only on sample ticks.
// Arithmetic uses one spare bit so that sums and differences clamp instead of wrapping.
module envelope_gen
    import synthPKG::*;
#(
    parameter int ENV_W = ENV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             gate_i,
    input  logic [ENV_W-1:0] attackRate_i,
    input  logic [ENV_W-1:0] decayRate_i,
    input  logic [ENV_W-1:0] releaseRate_i,
    input  logic [ENV_W-1:0] sustainLvl_i,
    output env_state_t       state_o,
    output logic [ENV_W-1:0] level_o
);

    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] level_q, level_d;
    logic [ENV_W:0]   attackSum;
    logic [ENV_W:0]   decayDiff;
    logic [ENV_W:0]   releaseDiff;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // A transition tick keeps the level; the new state's arithmetic starts on the next tick.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        attackSum   = {1'b0, level_q} + {1'b0, attackRate_i};
        decayDiff   = {1'b0, level_q} - {1'b0, decayRate_i};
        releaseDiff = {1'b0, level_q} - {1'b0, releaseRate_i};
        if (tick_i) begin
            case (state_q)
                IDLE: begin
                    level_d = '0;
                    if (gate_i) state_d = ATTACK;
                end
                ATTACK: begin
                    if (!gate_i) begin
                        state_d = RELEASE;
                    end else if (attackSum >= {1'b0, ENV_MAX}) begin
                        level_d = ENV_MAX;
                        state_d = DECAY;
                    end else begin
                        level_d = attackSum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    if (!gate_i) begin
                        state_d = RELEASE;
                    end else if (decayDiff[ENV_W] || (decayDiff[ENV_W-1:0] <= sustainLvl_i)) begin
                        level_d = sustainLvl_i;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = decayDiff[ENV_W-1:0];
                    end
                end
                SUSTAIN: begin
                    if (!gate_i) state_d = RELEASE;
                    else         level_d = sustainLvl_i;
                end
                RELEASE: begin
                    if (gate_i) begin
                        state_d = ATTACK;
                    end else if (releaseDiff[ENV_W] || (releaseDiff[ENV_W-1:0] == '0)) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = releaseDiff[ENV_W-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_o = state_q;
        level_o = level_q;
    end

endmodule

// File: rtl/envelope_mixer.sv
// Oscillator mixer with ADSR envelope: sums the enabled waveforms, scales by the envelope
// level and saturates to 16 bits through a two-stage pipeline strobed by SAMPLE_TICK.
module envelope_mixer
    import synthPKG::*;
#(
    parameter int ENV_W = ENV_W_DEF
) (
    input  logic             CLK_IN,
    input  logic             RESET,
    input  logic             SAMPLE_TICK,
    input  logic             GATE,
    input  synth_sig         TRI_IN,
    input  synth_sig         SQ_IN,
    input  synth_sig         SIN_IN,
    input  logic [2:0]       MIX_EN,
    input  logic [ENV_W-1:0] ATTACK_RATE,
    input  logic [ENV_W-1:0] DECAY_RATE,
    input  logic [ENV_W-1:0] RELEASE_RATE,
    input  logic [ENV_W-1:0] SUSTAIN_LVL,
    output synth_sig         SAMPLE_OUT,
    output logic             SAMPLE_VALID,
    output env_state_t       ENV_STATE,
    output logic [ENV_W-1:0] ENV_LEVEL
);

    localparam int PW = 18 + ENV_W + 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'(SYNTH_MAX);
    localparam logic signed [PW-1:0] SAT_LO = PW'(SYNTH_MIN);

    logic signed [17:0]      sum_q, sum_d;
    logic [ENV_W-1:0]        lvl_q;
    logic                    stage1Valid_q;
    synth_sig                sampleOut_q, sampleOut_d;
    logic                    sampleValid_q;
    logic signed [ENV_W:0]   lvlSigned;
    logic signed [PW-1:0]    product;
    logic signed [PW-1:0]    scaled;

    envelope_gen #(
        .ENV_W(ENV_W)
    ) u_envelope_gen (
        .clk_i        (CLK_IN),
        .rst_i        (RESET),
        .tick_i       (SAMPLE_TICK),
        .gate_i       (GATE),
        .attackRate_i (ATTACK_RATE),
        .decayRate_i  (DECAY_RATE),
        .releaseRate_i(RELEASE_RATE),
        .sustainLvl_i (SUSTAIN_LVL),
        .state_o      (ENV_STATE),
        .level_o      (ENV_LEVEL)
    );

    always_comb begin
        sum_d = (MIX_EN[0] ? 18'(SQ_IN)  : 18'sd0)
              + (MIX_EN[1] ? 18'(TRI_IN) : 18'sd0)
              + (MIX_EN[2] ? 18'(SIN_IN) : 18'sd0);
    end

    // The level is zero-extended so the multiply stays signed without flipping loud levels negative.
    always_comb begin
        lvlSigned = {1'b0, lvl_q};
        product   = PW'(sum_q) * PW'(lvlSigned);
        scaled    = product >>> ENV_W;
        if (scaled > SAT_HI)      sampleOut_d = SYNTH_MAX;
        else if (scaled < SAT_LO) sampleOut_d = SYNTH_MIN;
        else                      sampleOut_d = scaled[15:0];
    end

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            sum_q         <= '0;
            lvl_q         <= '0;
            stage1Valid_q <= 1'b0;
            sampleOut_q   <= '0;
            sampleValid_q <= 1'b0;
        end else begin
            stage1Valid_q <= SAMPLE_TICK;
            if (SAMPLE_TICK) begin
                sum_q <= sum_d;
                lvl_q <= ENV_LEVEL;
            end
            sampleValid_q <= stage1Valid_q;
            if (stage1Valid_q) sampleOut_q <= sampleOut_d;
        end
    end

    assign SAMPLE_OUT   = sampleOut_q;
    assign SAMPLE_VALID = sampleValid_q;

endmodule

// File: tb/tb_envelope_mixer.sv
// Directed bench for envelope_mixer: ADSR level sequences, mixer pipeline timing,
// saturation and asynchronous reset behaviour against hand-computed values.
module tb_envelope_mixer;
    import synthPKG::*;

    logic        CLK_IN;
    logic        RESET;
    logic        SAMPLE_TICK;
    logic        GATE;
    synth_sig    TRI_IN, SQ_IN, SIN_IN;
    logic [2:0]  MIX_EN;
    logic [7:0]  ATTACK_RATE, DECAY_RATE, RELEASE_RATE, SUSTAIN_LVL;
    synth_sig    SAMPLE_OUT;
    logic        SAMPLE_VALID;
    env_state_t  ENV_STATE;
    logic [7:0]  ENV_LEVEL;

    int checkCount = 0;
    int errorCount = 0;
    int validCount;

    int         t1Lvl [9] = '{0, 64, 128, 192, 255, 223, 191, 159, 128};
    env_state_t t1St  [9] = '{ATTACK, ATTACK, ATTACK, ATTACK, DECAY, DECAY, DECAY, DECAY, SUSTAIN};

    logic       t2Gate [17] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    env_state_t t2St   [17] = '{RELEASE, RELEASE, RELEASE, ATTACK, ATTACK, ATTACK, ATTACK,
                                DECAY, DECAY, DECAY, DECAY, SUSTAIN,
                                RELEASE, RELEASE, RELEASE, IDLE, IDLE};
    int         t2Lvl  [17] = '{128, 78, 28, 28, 92, 156, 220, 255, 223, 191, 159, 128,
                                128, 78, 28, 0, 0};

    envelope_mixer #(.ENV_W(8)) dut (
        .CLK_IN      (CLK_IN),
        .RESET       (RESET),
        .SAMPLE_TICK (SAMPLE_TICK),
        .GATE        (GATE),
        .TRI_IN      (TRI_IN),
        .SQ_IN       (SQ_IN),
        .SIN_IN      (SIN_IN),
        .MIX_EN      (MIX_EN),
        .ATTACK_RATE (ATTACK_RATE),
        .DECAY_RATE  (DECAY_RATE),
        .RELEASE_RATE(RELEASE_RATE),
        .SUSTAIN_LVL (SUSTAIN_LVL),
        .SAMPLE_OUT  (SAMPLE_OUT),
        .SAMPLE_VALID(SAMPLE_VALID),
        .ENV_STATE   (ENV_STATE),
        .ENV_LEVEL   (ENV_LEVEL)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle tick; returns at the falling edge right after the tick was clocked in.
    task automatic applyStimulus(input logic gate);
        @(negedge CLK_IN);
        GATE        = gate;
        SAMPLE_TICK = 1'b1;
        @(negedge CLK_IN);
        SAMPLE_TICK = 1'b0;
    endtask

    task automatic tickAndCheckSample(input string tag, input int expOut);
        applyStimulus(GATE);
        @(negedge CLK_IN);
        checkOutput({tag, "_valid"}, int'(SAMPLE_VALID), 1);
        checkOutput({tag, "_out"}, int'(SAMPLE_OUT), expOut);
        @(negedge CLK_IN);
    endtask

    initial begin
        RESET = 1'b1;  SAMPLE_TICK = 1'b0;  GATE = 1'b0;
        TRI_IN = '0;  SQ_IN = '0;  SIN_IN = '0;  MIX_EN = 3'b000;
        ATTACK_RATE = 8'd64;  DECAY_RATE = 8'd32;  RELEASE_RATE = 8'd50;  SUSTAIN_LVL = 8'd128;

        repeat (2) @(negedge CLK_IN);
        checkOutput("rstState", int'(ENV_STATE), int'(IDLE));
        checkOutput("rstLevel", int'(ENV_LEVEL), 0);
        checkOutput("rstOut", int'(SAMPLE_OUT), 0);
        checkOutput("rstValid", int'(SAMPLE_VALID), 0);
        RESET = 1'b0;

        SQ_IN  = 16'sd1000;
        MIX_EN = 3'b001;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("adState%0d", i), int'(ENV_STATE), int'(t1St[i]));
            checkOutput($sformatf("adLevel%0d", i), int'(ENV_LEVEL), t1Lvl[i]);
            repeat (2) @(negedge CLK_IN);
        end

        // Tick held for five cycles at level 128: 1000*128>>8 = 500 on every valid.
        @(negedge CLK_IN);
        SAMPLE_TICK = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK_IN);
            if (cyc == 5) SAMPLE_TICK = 1'b0;
            checkOutput($sformatf("burstValid%0d", cyc), int'(SAMPLE_VALID),
                        (cyc >= 2 && cyc <= 6) ? 1 : 0);
            if (cyc >= 2)
                checkOutput($sformatf("burstOut%0d", cyc), int'(SAMPLE_OUT), 500);
        end

        MIX_EN = 3'b000;
        tickAndCheckSample("mixOff", 0);

        SUSTAIN_LVL = 8'd255;
        applyStimulus(1'b1);
        checkOutput("susTo255", int'(ENV_LEVEL), 255);
        repeat (2) @(negedge CLK_IN);

        TRI_IN = 16'sd32767;  SQ_IN = 16'sd32767;  SIN_IN = 16'sd32767;  MIX_EN = 3'b111;
        tickAndCheckSample("satHi", 32767);
        TRI_IN = -16'sd32768;  SQ_IN = -16'sd32768;  SIN_IN = -16'sd32768;
        tickAndCheckSample("satLo", -32768);
        TRI_IN = -16'sd1000;  SIN_IN = 16'sd300;  SQ_IN = 16'sd200;  MIX_EN = 3'b110;
        tickAndCheckSample("mixTriSin", -698);
        MIX_EN = 3'b011;
        tickAndCheckSample("mixSqTri", -797);

        SUSTAIN_LVL = 8'd128;
        applyStimulus(1'b1);
        checkOutput("susBackLvl", int'(ENV_LEVEL), 128);
        repeat (2) @(negedge CLK_IN);

        // Release, retrigger at 28, full re-attack/decay, then release down to IDLE.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(t2Gate[i]);
            checkOutput($sformatf("relState%0d", i), int'(ENV_STATE), int'(t2St[i]));
            checkOutput($sformatf("relLevel%0d", i), int'(ENV_LEVEL), t2Lvl[i]);
            repeat (2) @(negedge CLK_IN);
        end

        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("preRstLevel", int'(ENV_LEVEL), 64);
        applyStimulus(1'b1);
        RESET = 1'b1;
        #1;
        checkOutput("asyncState", int'(ENV_STATE), int'(IDLE));
        checkOutput("asyncLevel", int'(ENV_LEVEL), 0);
        checkOutput("asyncValid", int'(SAMPLE_VALID), 0);
        validCount = 0;
        repeat (2) begin
            @(negedge CLK_IN);
            if (SAMPLE_VALID) validCount++;
        end
        RESET = 1'b0;
        repeat (4) begin
            @(negedge CLK_IN);
            if (SAMPLE_VALID) validCount++;
        end
        checkOutput("noValidAfterRst", validCount, 0);

        applyStimulus(1'b1);
        checkOutput("postRstState", int'(ENV_STATE), int'(ATTACK));
        checkOutput("postRstLevel", int'(ENV_LEVEL), 0);
        @(negedge CLK_IN);
        checkOutput("postRstValid", int'(SAMPLE_VALID), 1);
        checkOutput("postRstOut", int'(SAMPLE_OUT), 0);
        repeat (2) @(negedge CLK_IN);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/envelope_mixer.md
ENVELOPE_MIXER -- requirements
Module: envelope_mixer

Interface
REQ-001 The block SHALL have the parameter ENV_W, default 8, meaning the envelope level width; ENV_MAX is 2**ENV_W-1.
REQ-002 The block SHALL have these ports:
- CLK_IN  in  1  the single clock.
- RESET  in  1  asynchronous, active-high reset.
- SAMPLE_TICK  in  1  one-cycle sample-rate strobe.
- GATE  in  1  note on (1) / note off (0), level-sensitive.
- TRI_IN, SQ_IN, SIN_IN  in  synthPKG::synth_sig (signed 16)  oscillator waveforms.
- MIX_EN  in  3  per-waveform enable: bit0 SQ, bit1 TRI, bit2 SIN.
- ATTACK_RATE, DECAY_RATE, RELEASE_RATE  in  ENV_W  level step per tick.
- SUSTAIN_LVL  in  ENV_W  sustain level.
- SAMPLE_OUT  out  synth_sig  enveloped mixed sample.
- SAMPLE_VALID  out  1  one-cycle strobe qualifying SAMPLE_OUT.
- ENV_STATE  out  synthPKG::env_state_t  current envelope state.
- ENV_LEVEL  out  ENV_W  current envelope level, unsigned.

Function
REQ-003 State, level and pipeline registers SHALL change only on clock edges where SAMPLE_TICK=1, or in the pipeline stage following a tick; all other cycles hold.
REQ-004 The envelope FSM SHALL have the states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE.
REQ-005 IDLE: level=0; when GATE=1 at a tick, the FSM SHALL go to ATTACK and the level is unchanged on that tick.
REQ-006 ATTACK: the level SHALL be min(level+ATTACK_RATE, ENV_MAX); when it reaches ENV_MAX, the FSM goes to DECAY on the same tick.
REQ-007 DECAY: the level SHALL be max(level-DECAY_RATE, SUSTAIN_LVL); when it equals SUSTAIN_LVL, the FSM goes to SUSTAIN on the same tick.
REQ-008 SUSTAIN: the level SHALL track SUSTAIN_LVL on every tick.
REQ-009 GATE=0 at a tick in ATTACK, DECAY or SUSTAIN SHALL force RELEASE; release takes priority over the other transitions on that tick.
REQ-010 RELEASE: the level SHALL be max(level-RELEASE_RATE, 0); at 0 the FSM goes to IDLE.
REQ-011 GATE=1 at a tick in RELEASE SHALL go to ATTACK, keeping the current level (retrigger, no click).
REQ-012 A rate of 0 SHALL stall the FSM in its state.
- SUSTAIN_LVL=ENV_MAX makes DECAY exit to SUSTAIN immediately.
- SUSTAIN_LVL>level on entry to DECAY sets the level to SUSTAIN_LVL.
REQ-013 Add/subtract arithmetic SHALL be done at ENV_W+1 bits, with no wrap-around.
REQ-014 Mix: at a tick, stage 1 SHALL register the 18-bit signed sum of the enabled waveforms and the pre-update ENV_LEVEL.
REQ-015 Stage 2 SHALL compute (sum * {1'b0,level}) >>> ENV_W, arithmetic.
REQ-016 Stage 2 SHALL saturate the result to [-32768, 32767], register it into SAMPLE_OUT, and pulse SAMPLE_VALID.
REQ-017 Latency: SAMPLE_VALID SHALL be high for exactly 1 cycle, 2 cycles after the SAMPLE_TICK cycle.
REQ-018 Back-to-back ticks SHALL yield back-to-back valids.
REQ-019 MIX_EN=0 SHALL produce SAMPLE_OUT=0 with SAMPLE_VALID still pulsed.
REQ-020 SAMPLE_OUT SHALL hold its last value between valids.

Reset
REQ-021 While RESET=1, the block SHALL asynchronously set ENV_STATE=IDLE, ENV_LEVEL=0, SAMPLE_OUT=0, SAMPLE_VALID=0, and clear all pipeline registers.
REQ-022 Reset mid-note or mid-pipeline SHALL discard in-flight samples; no SAMPLE_VALID may occur for ticks sampled before reset release.
REQ-023 The first tick after reset release SHALL be processed normally.

Structure
REQ-024 synthPKG SHALL hold env_state_t (enum of the five states), ENV_W_DEF=8 and the saturation constants SYNTH_MAX and SYNTH_MIN.
REQ-025 The ADSR FSM and level datapath SHALL be the sub-module envelope_gen.
REQ-026 The mixer/multiplier pipeline SHALL remain in envelope_mixer.

Verification
REQ-027 Attack/decay scenario: GATE=1, ATTACK_RATE=64, DECAY_RATE=32, SUSTAIN_LVL=128, one tick per 4 cycles.
- Required levels: 0, 64, 128, 192, 255 (DECAY), 223, 191, 159, 128 (SUSTAIN).
REQ-028 Release scenario: from SUSTAIN 128, GATE=0, RELEASE_RATE=50.
- Required levels: 78, 28, 0, with IDLE reached on the tick that gives 0.
REQ-029 Retrigger scenario: GATE=1 while in RELEASE at level 28, ATTACK_RATE=64.
- Required: ATTACK with levels 28, 92.
- Required: no drop to 0.
REQ-030 Saturation scenario: all three inputs = 32767, MIX_EN=3'b111, level=255.
- Required: SAMPLE_OUT=32767.
- Required: SAMPLE_OUT=-32768 with all inputs at -32768.
REQ-031 Latency/throughput scenario: SQ_IN=1000, MIX_EN=3'b001, level=128, SAMPLE_TICK held high 5 cycles.
- Required: 5 consecutive valids starting 2 cycles later.
- Required: first SAMPLE_OUT=500.
REQ-032 Reset scenario: assert RESET 1 cycle after a tick in ATTACK.
- Required: no valid.
- Required: ENV_STATE=IDLE and ENV_LEVEL=0 immediately, not waiting for a clock edge.
